// File: rtl/tester_cycle_gen_if.sv
// Tester-cycle generator bus: burst control, timing configuration and the
// registered timing outputs that go to the pin format register.
interface tester_cycle_gen_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] lead;
    logic [CNT_W-1:0] trail;
    logic [CNT_W-1:0] num_cycles;
    logic             cycle;
    logic             vec_req;
    logic [CNT_W-1:0] cycle_idx;
    logic             busy;
    logic             done;
    logic             cfg_err;

    // Sequencer side: drives control and configuration, observes timing.
    modport master (
        output start, stop, period, lead, trail, num_cycles,
        input  cycle, vec_req, cycle_idx, busy, done, cfg_err
    );

    // Generator side.
    modport slave (
        input  start, stop, period, lead, trail, num_cycles,
        output cycle, vec_req, cycle_idx, busy, done, cfg_err
    );
endinterface

// File: rtl/tester_cycle_gen.sv
// Programmable tester-cycle timing generator. A phase counter runs
// 0..PERIOD-1 per tester cycle; CYCLE is high for LEAD <= T < TRAIL and
// VEC_REQ pulses at T = 0. Bursts are counted (NUM_CYCLES > 0) or
// free-running (NUM_CYCLES = 0). Every output is a register.
module tester_cycle_gen #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    tester_cycle_gen_if.slave bus
);
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nxt;

    // Configuration captured at START; input changes during RUN are ignored.
    logic [CNT_W-1:0] period_q, lead_q, trail_q, num_q;
    logic             load;

    logic [CNT_W-1:0] t_q, t_nxt;
    logic [CNT_W-1:0] idx_q, idx_nxt;
    logic             cycle_q, cycle_nxt;
    logic             vec_req_q, vec_req_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             cfg_err_q, cfg_err_nxt;

    logic             cfg_ok;
    logic             last_tick;
    logic             last_cycle;
    logic [CNT_W-1:0] phase_nxt;

    // 1 <= LEAD < TRAIL <= PERIOD, PERIOD >= 2, judged on the live inputs.
    assign cfg_ok = (bus.lead != '0) && (bus.lead < bus.trail) &&
                    (bus.trail <= bus.period) && (bus.period >= CNT_W'(2));

    assign last_tick  = (t_q == period_q - 1'b1);
    assign last_cycle = (num_q != '0) && (idx_q == num_q - 1'b1);
    assign phase_nxt  = last_tick ? '0 : t_q + 1'b1;

    // Next-state and next-output logic; outputs are derived from the phase
    // the counter is about to enter so they can be registered.
    always_comb begin
        // NOTE: every *_nxt signal gets a default first so no latch is inferred.
        state_nxt   = state;
        load        = 1'b0;
        t_nxt       = t_q;
        idx_nxt     = idx_q;
        cycle_nxt   = 1'b0;
        vec_req_nxt = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        cfg_err_nxt = cfg_err_q;

        unique case (state)
            IDLE: begin
                // STOP on the same tick masks START entirely.
                if (bus.start && !bus.stop) begin
                    if (cfg_ok) begin
                        load        = 1'b1;
                        state_nxt   = RUN;
                        t_nxt       = '0;
                        idx_nxt     = '0;
                        vec_req_nxt = 1'b1;
                        busy_nxt    = 1'b1;
                        cfg_err_nxt = 1'b0;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (last_tick && last_cycle) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    t_nxt       = phase_nxt;
                    idx_nxt     = last_tick ? idx_q + 1'b1 : idx_q;
                    busy_nxt    = 1'b1;
                    vec_req_nxt = (phase_nxt == '0);
                    cycle_nxt   = (phase_nxt >= lead_q) && (phase_nxt < trail_q);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, phase counter, shadow configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register updates together at the edge.
            state     <= IDLE;
            period_q  <= '0;
            lead_q    <= '0;
            trail_q   <= '0;
            num_q     <= '0;
            t_q       <= '0;
            idx_q     <= '0;
            cycle_q   <= 1'b0;
            vec_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            t_q       <= t_nxt;
            idx_q     <= idx_nxt;
            cycle_q   <= cycle_nxt;
            vec_req_q <= vec_req_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            cfg_err_q <= cfg_err_nxt;
            if (load) begin
                period_q <= bus.period;
                lead_q   <= bus.lead;
                trail_q  <= bus.trail;
                num_q    <= bus.num_cycles;
            end
        end
    end

    assign bus.cycle     = cycle_q;
    assign bus.vec_req   = vec_req_q;
    assign bus.cycle_idx = idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_tester_cycle_gen.sv
// Bench for tester_cycle_gen: table-driven bursts scored against a
// closed-form timing model, plus hand sequences for config errors,
// collisions, mid-burst reset and index wrap on a 4-bit instance.
module tb_tester_cycle_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tester_cycle_gen_if #(.CNT_W(16)) bus16 ();
    tester_cycle_gen_if #(.CNT_W(4))  bus4 ();

    tester_cycle_gen #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    tester_cycle_gen #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    typedef struct {
        string name;
        int    period;
        int    lead;
        int    trail;
        int    n;
        int    len;         // samples taken after the START edge
        int    stop_at;     // STOP driven after this sample, -1 = never
        int    chg_at;      // PERIOD input changed after this sample, -1 = never
        int    chg_val;
        int    restart_at;  // START re-driven during RUN after this sample
    } vec_t;

    typedef struct {
        logic        cycle;
        logic        vec_req;
        logic        busy;
        logic        done;
        logic        cfg_err;
        logic [15:0] idx;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs r ticks after the START edge, written directly from
    // the window/strobe/burst-length formulas.
    function automatic exp_t model(input vec_t v, input int r);
        exp_t e;
        int   t;
        e.cycle   = 1'b0;
        e.vec_req = 1'b0;
        e.busy    = 1'b0;
        e.done    = 1'b0;
        e.cfg_err = 1'b0;
        e.idx     = '0;
        if (v.stop_at >= 0 && r > v.stop_at) begin
            e.idx = 16'(v.stop_at / v.period);
        end else if (v.n > 0 && r >= v.n * v.period) begin
            e.done = (r == v.n * v.period);
            e.idx  = 16'(v.n - 1);
        end else begin
            t         = r % v.period;
            e.cycle   = (t >= v.lead) && (t < v.trail);
            e.vec_req = (t == 0);
            e.busy    = 1'b1;
            e.idx     = 16'(r / v.period);
        end
        return e;
    endfunction

    task automatic compare16(input string tag, input exp_t e);
        check({tag, ".cycle"},   32'(bus16.cycle),     32'(e.cycle));
        check({tag, ".vec_req"}, 32'(bus16.vec_req),   32'(e.vec_req));
        check({tag, ".busy"},    32'(bus16.busy),      32'(e.busy));
        check({tag, ".done"},    32'(bus16.done),      32'(e.done));
        check({tag, ".cfg_err"}, 32'(bus16.cfg_err),   32'(e.cfg_err));
        check({tag, ".idx"},     32'(bus16.cycle_idx), 32'(e.idx));
    endtask

    task automatic set_cfg(input int p, input int l, input int t, input int n);
        bus16.period     = 16'(p);
        bus16.lead       = 16'(l);
        bus16.trail      = 16'(t);
        bus16.num_cycles = 16'(n);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t got_exp;
        set_cfg(v.period, v.lead, v.trail, v.n);
        bus16.stop  = 1'b0;
        bus16.start = 1'b1;
        for (int r = 0; r < v.len; r++) begin
            sb.push_back(model(v, r));
            step();
            got_exp = sb.pop_front();
            compare16($sformatf("%s@%0d", v.name, r), got_exp);
            bus16.start = (r == v.restart_at);
            bus16.stop  = (r == v.stop_at);
            if (r == v.chg_at) bus16.period = 16'(v.chg_val);
        end
        bus16.start = 1'b0;
        bus16.stop  = 1'b0;
    endtask

    initial begin
        exp_t e4;

        vecs[0] = '{"burst3",    100, 40, 64, 3, 305,  -1, -1,  0, -1};
        vecs[1] = '{"min",         2,  1,  2, 4,  10,  -1, -1,  0, -1};
        vecs[2] = '{"abort",     100, 40, 64, 0, 155, 150, -1,  0, -1};
        vecs[3] = '{"latch",     100, 40, 64, 2, 203,  -1, 10, 50, 20};
        vecs[4] = '{"stop_last",   5,  1,  5, 1,   8,   4, -1,  0, -1};
        vecs[5] = '{"odd",         7,  3,  5, 2,  16,  -1, -1,  0, -1};

        bus16.start = 1'b0;
        bus16.stop  = 1'b0;
        set_cfg(0, 0, 0, 0);
        bus4.start      = 1'b0;
        bus4.stop       = 1'b0;
        bus4.period     = '0;
        bus4.lead       = '0;
        bus4.trail      = '0;
        bus4.num_cycles = '0;

        // Reset state.
        step();
        step();
        rst = 1'b0;
        compare16("reset", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});

        // Table-driven bursts.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Invalid configurations: LEAD = 0, TRAIL > PERIOD, LEAD > TRAIL.
        set_cfg(100, 0, 64, 0);
        bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        check("lead0.cfg_err", 32'(bus16.cfg_err), 32'd1);
        check("lead0.busy",    32'(bus16.busy),    32'd0);
        step();
        check("lead0.busy_hold", 32'(bus16.busy), 32'd0);

        set_cfg(50, 10, 60, 0);
        bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        check("trail_gt.cfg_err", 32'(bus16.cfg_err), 32'd1);
        check("trail_gt.busy",    32'(bus16.busy),    32'd0);

        set_cfg(100, 64, 40, 0);
        bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        check("swap.cfg_err", 32'(bus16.cfg_err), 32'd1);
        check("swap.busy",    32'(bus16.busy),    32'd0);

        // START+STOP together in IDLE: nothing changes, CFG_ERR stays set.
        set_cfg(100, 40, 64, 0);
        bus16.start = 1'b1;
        bus16.stop  = 1'b1;
        step();
        bus16.start = 1'b0;
        bus16.stop  = 1'b0;
        check("collide.busy",    32'(bus16.busy),    32'd0);
        check("collide.vec_req", 32'(bus16.vec_req), 32'd0);
        check("collide.cfg_err", 32'(bus16.cfg_err), 32'd1);

        // Valid START after an error clears CFG_ERR and runs.
        bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        check("recover.cfg_err", 32'(bus16.cfg_err), 32'd0);
        check("recover.busy",    32'(bus16.busy),    32'd1);
        check("recover.vec_req", 32'(bus16.vec_req), 32'd1);
        bus16.stop = 1'b1;
        step();
        bus16.stop = 1'b0;
        check("recover.stop_busy", 32'(bus16.busy), 32'd0);

        // Reset inside the window, then a clean first burst.
        set_cfg(100, 40, 64, 0);
        bus16.start = 1'b1;
        for (int r = 0; r <= 45; r++) begin
            step();
            bus16.start = 1'b0;
        end
        check("rst_mid.pre_cycle", 32'(bus16.cycle), 32'd1);
        check("rst_mid.pre_idx",   32'(bus16.cycle_idx), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        compare16("rst_mid", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
        run_vec(vecs[1]);

        // Free-run index wrap on the 4-bit instance.
        bus4.period     = 4'd2;
        bus4.lead       = 4'd1;
        bus4.trail      = 4'd2;
        bus4.num_cycles = 4'd0;
        bus4.start      = 1'b1;
        for (int r = 0; r < 40; r++) begin
            e4.cycle   = ((r % 2) == 1);
            e4.vec_req = ((r % 2) == 0);
            e4.busy    = 1'b1;
            e4.done    = 1'b0;
            e4.cfg_err = 1'b0;
            e4.idx     = 16'((r / 2) % 16);
            sb.push_back(e4);
            step();
            bus4.start = 1'b0;
            e4 = sb.pop_front();
            check($sformatf("wrap4.idx@%0d", r),  32'(bus4.cycle_idx), 32'(e4.idx));
            check($sformatf("wrap4.done@%0d", r), 32'(bus4.done),      32'(e4.done));
            check($sformatf("wrap4.cyc@%0d", r),  32'(bus4.cycle),     32'(e4.cycle));
        end
        bus4.stop = 1'b1;
        step();
        bus4.stop = 1'b0;
        check("wrap4.stop_busy", 32'(bus4.busy), 32'd0);
        check("wrap4.stop_done", 32'(bus4.done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
